regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised register file for the next-generation RISC-V datapath.
- Two combinational read ports and one synchronous write port.
- Optional hard-wired zero register and optional write-to-read bypass.
- Per-register pending (scoreboard) bits: the issue stage reserves a destination register, and writeback releases it. Decode uses the busy outputs to stall on RAW hazards.
- Sits between decode (read and reserve) and writeback (write).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, address width; register count NREG = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never reserved
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr_a  input  ADDR_W  read port A address
rd_addr_b  input  ADDR_W  read port B address
rd_data_a  output  DATA_W  read port A data
rd_data_b  output  DATA_W  read port B data
rd_busy_a  output  1  register at rd_addr_a has a pending write
rd_busy_b  output  1  register at rd_addr_b has a pending write
wr_en  input  1  write enable (writeback)
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rsv_en  input  1  reserve enable (issue)
rsv_addr  input  ADDR_W  register to mark pending
pend_cnt  output  ADDR_W+1  number of registers currently pending
rsv_err  output  1  registered, sticky: set when an already-pending register is reserved again

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- On reset (immediate, mid-cycle allowed):
  - all NREG registers clear to 0;
  - all pending bits clear to 0;
  - pend_cnt = 0, rsv_err = 0.
- Register 0 when ZERO_REG=1: writes and reservations to register 0 are ignored. Reads of register 0 return 0 with busy 0, including under bypass.
- Reads: combinational, zero latency.
  - rd_data_x = rf[rd_addr_x].
  - If BYPASS=1, wr_en=1, wr_addr==rd_addr_x and the address is not a ZERO_REG-suppressed 0, then rd_data_x = wr_data instead.
- Write: at the rising edge, if wr_en, rf[wr_addr] <= wr_data. The pending bit of wr_addr is cleared, unless a reservation of the same address happens in the same cycle.
- Reserve: at the rising edge, if rsv_en, pending[rsv_addr] <= 1.
  - If pending[rsv_addr] is already 1 and is not being cleared this cycle, rsv_err <= 1. It stays 1 until reset.
- Simultaneous write and reserve of the same address: data is written and pending ends at 1 (new reservation wins). rsv_err is not set.
- Write to a non-pending register: legal. Data is written; pending stays 0.
- Busy outputs:
  - rd_busy_x = pending[rd_addr_x].
  - If BYPASS=1 and the same-cycle write matches rd_addr_x, rd_busy_x = 0, since the data is forwarded.
  - Same-cycle reservations do not affect busy until the next cycle.
- pend_cnt: registered population count of the pending bits, updated on the same edge as the pending bits. Range 0..NREG, or 0..NREG-1 when ZERO_REG=1.
- Without bypass (BYPASS=0): a write becomes visible on reads the cycle after the edge. Busy for that address drops after the edge.
- Initial-block initialisation is not used; reset is the only init mechanism.

Test Plan:
1. Reset behaviour: hold rst_n=0, then release; read all 8 addresses -> every rd_data=0x0000, busy=0, pend_cnt=0, rsv_err=0.
2. Reserve then writeback:
   - rsv r3 -> next cycle rd_busy_a(r3)=1, pend_cnt=1.
   - wr r3=0xBEEF with BYPASS=1 -> same cycle rd_data_a=0xBEEF, rd_busy_a=0.
   - After the edge: pending cleared, pend_cnt=0.
3. Zero register: ZERO_REG=1, write r0=0x1234 and rsv r0 -> rd_data(r0)=0, busy=0, pend_cnt unchanged.
4. Collisions:
   - Same-cycle wr r5=0x00AA and rsv r5 (r5 previously pending) -> r5 reads 0x00AA, busy=1, rsv_err=0.
   - Then rsv r5 again -> rsv_err=1 and stays 1.
5. BYPASS=0 build: wr r2=0x5A5A -> same cycle rd_data(r2)=old value (0); next cycle 0x5A5A.
6. Asynchronous reset mid-operation: with r1..r7 reserved and written, assert rst_n between edges -> outputs clear immediately (pend_cnt=0, data=0) without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port and a
// per-register pending scoreboard used by decode to stall on RAW hazards.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              rsv_err
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_rf [NREG];
    logic [NREG-1:0]   r_pend;
    logic [CNT_W-1:0]  r_pend_cnt;
    logic              r_rsv_err;

    logic              w_wr_ok;
    logic              w_rsv_ok;
    logic              w_rsv_clash;
    logic              w_zero_a;
    logic              w_zero_b;
    logic              w_byp_a;
    logic              w_byp_b;
    logic [NREG-1:0]   w_pend_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Register 0 swallows writes and reservations when hard-wired to zero.
    assign w_wr_ok  = wr_en  && !(ZERO_REG && (wr_addr  == ADDR_W'(0)));
    assign w_rsv_ok = rsv_en && !(ZERO_REG && (rsv_addr == ADDR_W'(0)));

    // A reservation only clashes if the existing one is not being retired now.
    assign w_rsv_clash = w_rsv_ok && r_pend[rsv_addr]
                         && !(w_wr_ok && (wr_addr == rsv_addr));

    assign w_zero_a = ZERO_REG && (rd_addr_a == ADDR_W'(0));
    assign w_zero_b = ZERO_REG && (rd_addr_b == ADDR_W'(0));
    assign w_byp_a  = BYPASS && w_wr_ok && (wr_addr == rd_addr_a);
    assign w_byp_b  = BYPASS && w_wr_ok && (wr_addr == rd_addr_b);

    // Next pending vector: writeback clears, a same-cycle reservation wins.
    always_comb begin
        w_pend_nxt = r_pend;
        w_cnt_nxt  = '0;
        if (w_wr_ok) begin
            w_pend_nxt[wr_addr] = 1'b0;
        end
        if (w_rsv_ok) begin
            w_pend_nxt[rsv_addr] = 1'b1;
        end
        for (int unsigned i = 0; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_pend_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_rf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
            r_rsv_err  <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_cnt_nxt;
            if (w_rsv_clash) begin
                r_rsv_err <= 1'b1;
            end
        end
    end

    // Read port A: array lookup, then forwarding, then the zero override.
    always_comb begin
        rd_data_a = r_rf[rd_addr_a];
        rd_busy_a = r_pend[rd_addr_a];
        if (w_byp_a) begin
            rd_data_a = wr_data;
            rd_busy_a = 1'b0;
        end
        if (w_zero_a) begin
            rd_data_a = '0;
            rd_busy_a = 1'b0;
        end
    end

    always_comb begin
        rd_data_b = r_rf[rd_addr_b];
        rd_busy_b = r_pend[rd_addr_b];
        if (w_byp_b) begin
            rd_data_b = wr_data;
            rd_busy_b = 1'b0;
        end
        if (w_zero_b) begin
            rd_data_b = '0;
            rd_busy_b = 1'b0;
        end
    end

    assign pend_cnt = r_pend_cnt;
    assign rsv_err  = r_rsv_err;

endmodule
